// File: rtl/cnt_chk_pkg.sv
// Shared definitions for the bounce-at-max counter and its checkers:
// checker state encoding and the counter successor function.
package cnt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Successor on w bits: count up, bounce back by one at all-ones, never wrap.
  function automatic logic [31:0] succ(input logic [31:0] x, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (x == top) ? x - 32'd1 : x + 32'd1;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with clear; clear together with increment yields 1.
// Counter value is registered; no backpressure.
module sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? WIDTH'(1) : '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cnt_seq_chk.sv
// Sequence checker for the bounce-at-max counter: locks after LOCK_N matches, flags misses.
// All outputs registered or register-derived, one cycle after a sample; never backpressures.
module cnt_seq_chk #(
  parameter int W      = 5,
  parameter int LOCK_N = 4,
  parameter int MISS_N = 3,
  parameter int ECW    = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  input  logic           clr_err,
  output logic           locked,
  output logic           err,
  output logic [ECW-1:0] err_cnt,
  output logic [W-1:0]   exp_data
);
  import cnt_chk_pkg::*;

  localparam logic [3:0] LOCK_C = 4'(LOCK_N);
  localparam logic [3:0] MISS_C = 4'(MISS_N);

  state_t       state_q, state_d;
  logic [W-1:0] prev_q, prev_d;
  logic [3:0]   run_q, run_d;
  logic [3:0]   miss_q, miss_d;
  logic         err_q, err_d;
  logic [31:0]  f_full;
  logic [W-1:0] f_prev;
  logic         match;

  assign f_full = succ(32'(prev_q), W);
  assign f_prev = f_full[W-1:0];
  assign match  = (in_data == f_prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      run_q   <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          prev_d  = in_data;
          run_d   = '0;
          state_d = ACQ;
        end
        ACQ: begin
          prev_d = in_data;
          if (match) begin
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 == LOCK_C) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            prev_d = in_data;
            miss_d = '0;
          end else begin
            // Flywheel on the prediction so one corrupted sample costs one error.
            err_d  = 1'b1;
            miss_d = miss_q + 4'd1;
            prev_d = f_prev;
            if (miss_q + 4'd1 == MISS_C) begin
              state_d = ACQ;
              run_d   = '0;
              prev_d  = in_data;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  sat_cnt #(.WIDTH(ECW)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_d),
    .clr   (clr_err),
    .cnt   (err_cnt)
  );

  assign locked   = (state_q == LOCKED);
  assign err      = err_q;
  assign exp_data = (state_q == IDLE) ? '0 : f_prev;

endmodule

// File: tb/tb_cnt_seq_chk.sv
// Scoreboard bench: directed plan scenarios plus random stream, against a behavioural model.
module tb_cnt_seq_chk;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = '0;
  logic       clr_err = 1'b0;

  logic       locked_a, err_a, locked_b, err_b;
  logic [7:0] err_cnt_a;
  logic [2:0] err_cnt_b;
  logic [4:0] exp_a, exp_b;

  always #5 clk = ~clk;

  cnt_seq_chk #(.W(5), .LOCK_N(4), .MISS_N(3), .ECW(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked_a), .err(err_a), .err_cnt(err_cnt_a), .exp_data(exp_a)
  );

  cnt_seq_chk #(.W(5), .LOCK_N(4), .MISS_N(3), .ECW(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked_b), .err(err_b), .err_cnt(err_cnt_b), .exp_data(exp_b)
  );

  typedef struct {
    int locked;
    int err;
    int c8;
    int c3;
    int ex;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model: plain procedural rendering of the checker rules.
  bit m_seen, m_locked;
  int m_prev, m_run, m_miss, m_c8, m_c3;

  function automatic int succ5(input int x);
    return (x == 31) ? 30 : x + 1;
  endfunction

  function automatic int pred();
    return m_seen ? succ5(m_prev) : 0;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input bit v, input int d, input bit clr, input bit rst);
    exp_t e;
    bit   bad;
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    in_data  = 5'(d);
    clr_err  = clr;
    bad = 1'b0;
    if (rst) begin
      m_seen = 0; m_locked = 0; m_prev = 0; m_run = 0; m_miss = 0; m_c8 = 0; m_c3 = 0;
    end else begin
      if (v) begin
        if (!m_seen) begin
          m_seen = 1; m_prev = d; m_run = 0;
        end else if (!m_locked) begin
          if (d == succ5(m_prev)) begin
            m_run++;
            if (m_run == 4) begin m_locked = 1; m_miss = 0; end
          end else m_run = 0;
          m_prev = d;
        end else if (d == succ5(m_prev)) begin
          m_prev = d; m_miss = 0;
        end else begin
          bad = 1'b1;
          m_miss++;
          if (m_miss == 3) begin m_locked = 0; m_run = 0; m_prev = d; end
          else m_prev = succ5(m_prev);
        end
      end
      if (clr) begin
        m_c8 = bad ? 1 : 0;
        m_c3 = bad ? 1 : 0;
      end else if (bad) begin
        if (m_c8 < 255) m_c8++;
        if (m_c3 < 7) m_c3++;
      end
    end
    e.locked = m_locked;
    e.err    = bad;
    e.c8     = m_c8;
    e.c3     = m_c3;
    e.ex     = m_seen ? succ5(m_prev) : 0;
    sb.push_back(e);
  endtask

  task automatic feed(input int d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic feed_ok();
    step(1'b1, pred(), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("locked", int'(locked_a), e.locked);
        chk("err", int'(err_a), e.err);
        chk("err_cnt", int'(err_cnt_a), e.c8);
        chk("exp_data", int'(exp_a), e.ex);
        chk("err_cnt_ecw3", int'(err_cnt_b), e.c3);
      end
    end
  end

  initial begin : stim
    do_reset();
    // Lock from 0, run through the bounce region.
    for (int i = 0; i <= 4; i++) feed(i);
    for (int i = 0; i < 30; i++) feed_ok();
    // Lock with prev=10, one corrupt sample, flywheel match.
    do_reset();
    for (int i = 5; i <= 10; i++) feed(i);
    feed(7);
    feed(12);
    feed_ok();
    // Three misses drop lock, then relock from 1.
    do_reset();
    for (int i = 5; i <= 10; i++) feed(i);
    feed(0); feed(0); feed(0);
    for (int i = 1; i <= 4; i++) feed(i);
    // Build errors, clear alone, clear with an error, then saturate ECW=3.
    for (int i = 0; i < 5; i++) begin feed(0); feed_ok(); end
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 0, 1'b1, 1'b0);
    feed_ok();
    for (int i = 0; i < 10; i++) begin feed(0); feed_ok(); end
    // Valid gaps while locked, then reset while locked.
    for (int i = 0; i < 12; i++) begin
      int g;
      g = $urandom_range(1, 3);
      for (int k = 0; k < g; k++) step(1'b0, $urandom_range(0, 31), 1'b0, 1'b0);
      feed_ok();
    end
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 9, 1'b1, 1'b0);
    // Random stream: mostly correct samples, some corruption, clears and resets.
    for (int i = 0; i < 600; i++) begin
      bit v, clr, rst;
      int d;
      rst = ($urandom_range(0, 149) == 0);
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 24) == 0);
      d   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : pred();
      step(v, d, clr, rst);
    end
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
